// File: rtl/serial_alu_pkg.sv
// Shared opcode constants and FSM state encoding for the bit-serial ALU.
package serial_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: full adder for ADD/SUB, plain gates for AND/OR.
module alu_bit_slice
    import serial_alu_pkg::*;
(
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       res_bit,
    output logic       cout
);

    always_comb begin
        res_bit = 1'b0;
        cout    = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res_bit = a_bit ^ b_bit ^ cin;
                cout    = (a_bit & b_bit) | (cin & (a_bit ^ b_bit));
            end
            OP_AND: res_bit = a_bit & b_bit;
            OP_OR:  res_bit = a_bit | b_bit;
            default: begin
                res_bit = 1'b0;
                cout    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial N-bit ALU: one bit per clock through a single slice, LSB first,
// with a start/busy/done handshake and registered result/flags.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Handshake: start is taken at any edge where state is not S_RUN; busy is
    // high from the accepting edge until the completing edge, when done pulses.
    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [1:0]       op_r;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             b_in;
    logic             slice_res;
    logic             slice_cout;
    logic             is_arith;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    // Subtraction is a + ~b + 1: invert b on entry, seed the carry with 1.
    assign b_in     = b_sr[0] ^ (op_r == OP_SUB);
    assign is_arith = ~op_r[1];
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign res_next = {slice_res, res_sr[WIDTH-1:1]};

    alu_bit_slice u_slice (
        .a_bit   (a_sr[0]),
        .b_bit   (b_in),
        .cin     (carry),
        .op      (op_r),
        .res_bit (slice_res),
        .cout    (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            op_r      <= OP_ADD;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        op_r   <= op;
                        res_sr <= '0;
                        carry  <= (op == OP_SUB);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= slice_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // carry still holds the carry into the MSB here
                        result    <= res_next;
                        carry_out <= is_arith & slice_cout;
                        overflow  <= is_arith & (carry ^ slice_cout);
                        zero      <= (res_next == '0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu: driver tasks push expected responses into a
// queue, a monitor pops and compares on every done pulse.
module tb_serial_alu;

    localparam int WIDTH = 8;
    localparam int EW    = WIDTH + 3;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] OR  = 2'b11;

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    logic [EW-1:0]    exp_q[$];
    int               total = 0;
    int               bad   = 0;
    int               done_cnt = 0;
    int               push_cnt = 0;
    logic [WIDTH-1:0] last_res = '0;

    serial_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("result_flags", 32'({result, carry_out, overflow, zero}), 32'(e));
            end
        end
    end

    // driver: called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [WIDTH-1:0] r, input logic c, input logic v, input logic z);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back({r, c, v, z});
        push_cnt++;
        @(negedge clk);
        start = 1'b0;
        a     = ~x;
        b     = ~y;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_low_after_start", 32'(done), 32'd0);
        check("result_held", 32'(result), 32'(last_res));
        last_res = r;
    endtask

    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) check("done_timeout", 32'(lat), 32'd0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [WIDTH-1:0] r, input logic c, input logic v, input logic z);
        int lat;
        int bc;
        issue(o, x, y, r, c, v, z);
        wait_done(lat, bc);
        check("latency", 32'(lat), 32'(WIDTH));
        check("busy_cycles", 32'(bc), 32'(WIDTH));
        check("busy_low_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int bc;
        reset = 1'b1;
        start = 1'b0;
        op    = ADD;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_outputs", 32'({busy, done, result, carry_out, overflow, zero}), 32'd0);
        @(negedge clk);

        do_op(ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        do_op(ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        do_op(SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
        do_op(SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0);
        do_op(SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        do_op(AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        do_op(OR,  8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);

        // start while busy must be ignored
        issue(ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        op    = ADD;
        a     = 8'h10;
        b     = 8'h20;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("latency_busy_ignore", 32'(lat), 32'(WIDTH - 3));

        // start in the DONE cycle: back-to-back with no idle gap
        issue(AND, 8'hAA, 8'h0F, 8'h0A, 1'b0, 1'b0, 1'b0);
        wait_done(lat, bc);
        check("latency_back_to_back", 32'(lat), 32'(WIDTH));
        @(negedge clk);

        // reset three cycles into an operation aborts it
        issue(ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        void'(exp_q.pop_back());
        push_cnt--;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_outputs", 32'({busy, done, result, carry_out, overflow, zero}), 32'd0);
        last_res = '0;
        repeat (2 * WIDTH) @(negedge clk);
        check("no_done_after_abort", 32'(done_cnt), 32'(push_cnt));

        do_op(ADD, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("done_pulse_count", 32'(done_cnt), 32'(push_cnt));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Bit-serial, parametrised N-bit ALU.
- Processes one bit per clock through a single 1-bit add/logic slice, LSB first. This is the multi-bit, sequential successor of the lab's 1-bit ALU.
- Start/busy/done handshake. Registered result and flags are held stable between operations.
- Sits in the lab datapath as a low-area arithmetic unit driven by a simple controller.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only when not busy
- op  input  2  operation code: 00 ADD, 01 SUB, 10 AND, 11 OR
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result and flags become valid
- result  output  WIDTH  registered result
- carry_out  output  1  final carry (ADD), not-borrow (SUB), 0 for logic ops
- overflow  output  1  signed overflow for ADD/SUB, 0 for logic ops
- zero  output  1  high when result equals 0

Behaviour:
- Reset is synchronous and active-high on clk. While reset is high at an edge:
  - state goes to IDLE;
  - busy, done, result, carry_out, overflow and zero all go to 0;
  - internal shift registers, bit counter and carry flop are cleared.
- Reset mid-operation aborts the operation; no done pulse follows.
- States and transitions:
  - IDLE: start=1 accepts the operation and moves to RUN.
  - RUN: exactly WIDTH cycles, then moves to DONE.
  - DONE: lasts one cycle; returns to IDLE, or goes directly to RUN if start=1 in that cycle.
- On accepted start:
  - latch a, b and op into internal registers;
  - bit counter = 0;
  - carry flop = 1 for SUB, 0 otherwise;
  - for SUB, the B operand is inverted bitwise as it enters the slice.
- Each RUN cycle:
  - slice computes on operand bit 0 of the shift registers plus the carry flop;
  - sum/logic bit shifts into the MSB of the internal result shift register;
  - operand registers shift right; carry flop updates; counter increments;
  - on the final (MSB) cycle, carry into the MSB is captured for overflow.
- Arithmetic rules:
  - overflow = carry into MSB XOR carry out of MSB;
  - for SUB, carry_out=1 means a >= b (unsigned).
  - Logic ops ignore the carry chain and force carry_out=0, overflow=0.
- Timing and latency:
  - busy rises on the edge that accepts start and stays high for WIDTH cycles.
  - At the edge ending the last RUN cycle: result, carry_out, overflow and zero update together and done is driven high for one cycle.
  - Latency: start sampled at edge k → done high after edge k+WIDTH, low again after edge k+WIDTH+1 unless a new completion occurs.
- Output stability: result and flags change only at completion or reset. They hold the previous operation's values while busy.
- start while busy (RUN) is ignored, and a, b and op changes during RUN are ignored.
- start asserted during the DONE cycle is accepted, giving back-to-back operations with no idle gap.
- op values are fully decoded; no illegal encodings.
- Counter width is clog2(WIDTH+1).

Decomposition:
- Package serial_alu_pkg holds:
  - op code constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11;
  - FSM state encoding S_IDLE, S_RUN, S_DONE.
- One natural sub-module: alu_bit_slice.
  - Purely combinational: inputs a_bit, b_bit, cin, op; outputs res_bit, cout.
  - Instantiated once. Contains the full adder and AND/OR mux.
- FSM, counter, shift registers and flag logic live in serial_alu.

Test Plan (WIDTH=8):
- ADD a=8'h7F, b=8'h01 → result 8'h80, carry_out 0, overflow 1, zero 0; done exactly 8 edges after the accepting edge; busy high for 8 cycles.
- ADD a=8'hFF, b=8'h01 → result 8'h00, carry_out 1, overflow 0, zero 1.
- SUB a=8'h05, b=8'h05 → 8'h00, carry_out 1, zero 1. Then SUB a=8'h03, b=8'h05 → 8'hFE, carry_out 0, overflow 0. Then SUB a=8'h80, b=8'h01 → 8'h7F, overflow 1.
- AND a=8'hF0, b=8'h3C → 8'h30, carry_out 0, overflow 0. Then OR on the same operands → 8'hFC.
- Pulse start with ADD 8'h10+8'h20 while busy with a prior ADD 8'h01+8'h01 → only 8'h02 is produced and exactly one done pulse occurs. Then assert start in the DONE cycle with AND 8'hAA & 8'h0F → 8'h0A, with no idle cycle between operations.
- Reset asserted 3 cycles into ADD 8'h7F+8'h01 → next cycle busy 0, done 0, result 8'h00, all flags 0, and no later done pulse. A fresh ADD 8'h02+8'h03 then yields 8'h05.
